// File: rtl/regif_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regif_arb_pkg
// Description : Shared types and helpers for the register-interface arbiter.
// Revision    : 1.0
// ============================================================================
package regif_arb_pkg;

    localparam int MAXN   = 16;
    localparam int REQ_AW = 64;
    localparam int REQ_RW = 32;

    typedef struct packed {
        logic              write;
        logic              lock;
        logic [REQ_AW-1:0] addr;
        logic [REQ_RW-1:0] wrdata;
    } regif_req_t;

    // Index width for N requesters; never zero so a single-bit index always exists.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regif_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : regif_rr_picker
// Description : Combinational round-robin pick: first set request at or above ptr, wrapping.
// Revision    : 1.0
// ============================================================================
module regif_rr_picker #(
    parameter int N   = 2,
    parameter int IDW = 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] index,
    output logic           any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                index    = j[IDW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regif_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regif_arbiter
// Description : Round-robin arbiter with lock sharing one 1-cycle-latency register target.
// Revision    : 1.0
// ============================================================================
module regif_arbiter
    import regif_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 64,
    parameter int RW = 32
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_write,
    input  logic [N-1:0]    req_lock,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*RW-1:0] req_wrdata,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    resp_valid,
    output logic [RW-1:0]   resp_rddata,
    output logic            mem_ce,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [RW-1:0]   mem_wrdata,
    input  logic [RW-1:0]   mem_rddata
);

    localparam int IDW = clog2_min1(N);
    localparam logic [IDW-1:0] c_LAST = IDW'(N - 1);

    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_lock_owner;
    logic           r_lock_active;
    logic           r_rd_pend;
    logic [N-1:0]   r_resp_valid;

    logic [N-1:0]   w_owner_mask;
    logic [N-1:0]   w_pick_req;
    logic [IDW-1:0] w_pick_ptr;
    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_gidx;
    logic           w_any;
    logic           w_write;
    logic           w_lock;
    logic [AW-1:0]  w_addr;
    logic [RW-1:0]  w_wrdata;

    generate
        for (genvar i = 0; i < N; i++) begin : g_owner_mask
            assign w_owner_mask[i] = (r_lock_owner == IDW'(i));
        end
    endgenerate

    // While locked, everyone but the owner is masked out even if the owner is idle.
    assign w_pick_req = r_lock_active ? (req_valid & w_owner_mask) : req_valid;
    assign w_pick_ptr = r_lock_active ? r_lock_owner : r_rr_ptr;

    regif_rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .req   (w_pick_req),
        .ptr   (w_pick_ptr),
        .grant (w_grant),
        .index (w_gidx),
        .any   (w_any)
    );

    always_comb begin
        w_addr   = '0;
        w_wrdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_addr   = w_addr   | req_addr[i*AW +: AW];
                w_wrdata = w_wrdata | req_wrdata[i*RW +: RW];
            end
        end
    end

    assign w_write = |(w_grant & req_write);
    assign w_lock  = |(w_grant & req_lock);

    assign req_ready   = w_grant;
    assign mem_ce      = w_any;
    assign mem_we      = w_write;
    assign mem_addr    = w_addr;
    assign mem_wrdata  = w_wrdata;
    assign resp_valid  = r_resp_valid;
    assign resp_rddata = r_rd_pend ? mem_rddata : '0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rr_ptr      <= '0;
            r_lock_owner  <= '0;
            r_lock_active <= 1'b0;
            r_rd_pend     <= 1'b0;
            r_resp_valid  <= '0;
        end else begin
            r_resp_valid <= w_grant;
            r_rd_pend    <= w_any & ~w_write;
            if (w_any) begin
                if (w_lock) begin
                    r_lock_active <= 1'b1;
                    r_lock_owner  <= w_gidx;
                end else begin
                    // Covers both a plain unlocked access and the owner releasing its lock.
                    r_lock_active <= 1'b0;
                    r_rr_ptr      <= (w_gidx == c_LAST) ? '0 : w_gidx + IDW'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regif_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regif_arbiter
// Description : Directed scoreboard bench for regif_arbiter with N=3 and a 1-cycle SRAM model.
// Revision    : 1.0
// ============================================================================
module tb_regif_arbiter;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int RW = 32;

    logic            clk = 1'b0;
    logic            nreset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*RW-1:0] req_wrdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [RW-1:0]   resp_rddata;
    logic            mem_ce;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [RW-1:0]   mem_wrdata;
    logic [RW-1:0]   mem_rddata;

    regif_arbiter #(.N(N), .AW(AW), .RW(RW)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wrdata  (req_wrdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_rddata (resp_rddata),
        .mem_ce      (mem_ce),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wrdata  (mem_wrdata),
        .mem_rddata  (mem_rddata)
    );

    always #5 clk = ~clk;

    // Target model: untouched location a reads back 0xA0000000 | a.
    logic        mem_init = 1'b1;
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem_rddata <= '0;
        end else if (mem_ce) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wrdata;
            else        mem_rddata <= mem[mem_addr[7:0]];
        end
    end

    typedef struct {
        logic [N-1:0] id;
        logic         rd;
        logic [31:0]  data;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor, decoupled from stimulus.
    always @(negedge clk) begin
        if (resp_valid != '0) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                m_e = q.pop_front();
                chk("resp_valid", 64'(resp_valid), 64'(m_e.id));
                chk(m_e.rd ? "resp_rddata" : "resp_rddata_wr", 64'(resp_rddata),
                    m_e.rd ? 64'(m_e.data) : 64'd0);
            end
        end
    end

    task automatic step(input logic [2:0] v, input logic [2:0] w, input logic [2:0] l,
                        input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                        input logic [31:0] wd, input logic [2:0] exp_rdy, input logic [31:0] exp_data);
        exp_t e;
        logic [7:0] ea;
        @(posedge clk);
        #1;
        req_valid  = v;
        req_write  = w;
        req_lock   = l;
        req_addr   = {56'h0, a2, 56'h0, a1, 56'h0, a0};
        req_wrdata = {3{wd}};
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("mem_ce", 64'(mem_ce), 64'(|exp_rdy));
        if (exp_rdy != 3'b000) begin
            ea = exp_rdy[0] ? a0 : (exp_rdy[1] ? a1 : a2);
            chk("mem_addr", mem_addr, {56'h0, ea});
            chk("mem_we", 64'(mem_we), 64'(|(exp_rdy & w)));
            e.id   = exp_rdy;
            e.rd   = ~|(exp_rdy & w);
            e.data = exp_data;
            q.push_back(e);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_mem_ce"},     64'(mem_ce), 64'd0);
        chk({tag, "_mem_we"},     64'(mem_we), 64'd0);
        chk({tag, "_mem_addr"},   mem_addr, 64'd0);
        chk({tag, "_mem_wrdata"}, 64'(mem_wrdata), 64'd0);
        chk({tag, "_resp_rddata"}, 64'(resp_rddata), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_valid = '0;
        nreset    = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        nreset   = 1'b1;
        @(negedge clk);
        chk_idle("reset");

        // Write then read back through requester 0
        step(3'b001, 3'b001, 3'b000, 8'h10, 8'h00, 8'h00, 32'hDEAD_BEEF, 3'b001, 32'h0);
        step(3'b001, 3'b000, 3'b000, 8'h10, 8'h00, 8'h00, 32'h0, 3'b001, 32'hDEAD_BEEF);
        step(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 32'h0, 3'b000, 32'h0);

        // All three continuously valid: strict rotation with no bubbles
        do_reset();
        step(3'b111, 3'b000, 3'b000, 8'h20, 8'h21, 8'h22, 32'h0, 3'b001, 32'hA000_0020);
        step(3'b111, 3'b000, 3'b000, 8'h20, 8'h21, 8'h22, 32'h0, 3'b010, 32'hA000_0021);
        step(3'b111, 3'b000, 3'b000, 8'h20, 8'h21, 8'h22, 32'h0, 3'b100, 32'hA000_0022);
        step(3'b111, 3'b000, 3'b000, 8'h20, 8'h21, 8'h22, 32'h0, 3'b001, 32'hA000_0020);
        step(3'b111, 3'b000, 3'b000, 8'h20, 8'h21, 8'h22, 32'h0, 3'b010, 32'hA000_0021);
        step(3'b111, 3'b000, 3'b000, 8'h20, 8'h21, 8'h22, 32'h0, 3'b100, 32'hA000_0022);

        // Lock held by requester 1 across idle cycles, requester 0 starved until release
        step(3'b011, 3'b000, 3'b000, 8'h40, 8'h41, 8'h00, 32'h0, 3'b001, 32'hA000_0040);
        step(3'b011, 3'b010, 3'b010, 8'h40, 8'h31, 8'h00, 32'h1111_1111, 3'b010, 32'h0);
        step(3'b011, 3'b000, 3'b010, 8'h40, 8'h31, 8'h00, 32'h0, 3'b010, 32'h1111_1111);
        step(3'b001, 3'b000, 3'b000, 8'h40, 8'h31, 8'h00, 32'h0, 3'b000, 32'h0);
        step(3'b001, 3'b000, 3'b000, 8'h40, 8'h31, 8'h00, 32'h0, 3'b000, 32'h0);
        step(3'b011, 3'b000, 3'b010, 8'h40, 8'h31, 8'h00, 32'h0, 3'b010, 32'h1111_1111);
        step(3'b011, 3'b000, 3'b000, 8'h40, 8'h31, 8'h00, 32'h0, 3'b010, 32'h1111_1111);
        step(3'b001, 3'b000, 3'b000, 8'h40, 8'h31, 8'h00, 32'h0, 3'b001, 32'hA000_0040);

        // Pointer wrap from N-1 back to 0
        step(3'b010, 3'b000, 3'b000, 8'h00, 8'h42, 8'h00, 32'h0, 3'b010, 32'hA000_0042);
        step(3'b100, 3'b000, 3'b000, 8'h00, 8'h00, 8'h43, 32'h0, 3'b100, 32'hA000_0043);
        step(3'b011, 3'b000, 3'b000, 8'h44, 8'h46, 8'h00, 32'h0, 3'b001, 32'hA000_0044);
        step(3'b001, 3'b000, 3'b000, 8'h45, 8'h00, 8'h00, 32'h0, 3'b001, 32'hA000_0045);

        // Reset while a locked read is in flight
        step(3'b100, 3'b000, 3'b100, 8'h00, 8'h00, 8'h50, 32'h0, 3'b100, 32'hA000_0050);
        step(3'b001, 3'b000, 3'b000, 8'h60, 8'h00, 8'h50, 32'h0, 3'b000, 32'h0);
        @(posedge clk);
        #1;
        req_valid = 3'b101;
        req_write = 3'b000;
        req_lock  = 3'b100;
        req_addr  = {56'h0, 8'h51, 56'h0, 8'h00, 56'h0, 8'h60};
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(3'b100));
        nreset    = 1'b0;
        req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        chk_idle("post_rst");
        step(3'b011, 3'b000, 3'b000, 8'h70, 8'h71, 8'h00, 32'h0, 3'b001, 32'hA000_0070);

        step(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 32'h0, 3'b000, 32'h0);
        step(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 32'h0, 3'b000, 32'h0);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
